// File: rtl/spgd_seq_ctrl.sv
// Iteration sequencer for the two-channel SPGD datapath: perturb, measure J+ and J-, commit U.
// Moore outputs decoded from the registered state; one shared counter times settle and ADC waits.
module spgd_seq_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 ADC_CLK,
  input  logic                 RST_N,
  input  logic                 SYS_EN,
  input  logic                 ADC_DONE,
  input  logic [CNT_WIDTH-1:0] SETTLE_TIME,
  input  logic [CNT_WIDTH-1:0] ADC_TIMEOUT,
  input  logic [CNT_WIDTH-1:0] ITER_LIMIT,
  output logic                 ADC_EN,
  output logic                 REG_RST,
  output logic                 RNG_CLK,
  output logic                 DELTA_U_WRT,
  output logic                 J_P_WRT,
  output logic                 J_M_WRT,
  output logic                 U_WRT,
  output logic [1:0]           DAC_SEL,
  output logic [3:0]           FSM_STATE,
  output logic [CNT_WIDTH-1:0] ITER_CNT,
  output logic                 BUSY,
  output logic                 ERR
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_CLEAR    = 4'd1;
  localparam logic [3:0] S_NEW_PERT = 4'd2;
  localparam logic [3:0] S_SET_P    = 4'd3;
  localparam logic [3:0] S_SETTLE_P = 4'd4;
  localparam logic [3:0] S_MEAS_P   = 4'd5;
  localparam logic [3:0] S_LATCH_P  = 4'd6;
  localparam logic [3:0] S_SET_M    = 4'd7;
  localparam logic [3:0] S_SETTLE_M = 4'd8;
  localparam logic [3:0] S_MEAS_M   = 4'd9;
  localparam logic [3:0] S_LATCH_M  = 4'd10;
  localparam logic [3:0] S_UPDATE   = 4'd11;
  localparam logic [3:0] S_DONE     = 4'd12;
  localparam logic [3:0] S_FAULT    = 4'd13;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic [3:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] iter_q, iter_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] settle_load_s;
  logic [CNT_WIDTH-1:0] iter_inc_s;
  logic                 tmo_hit_s;

  // A zero settle time still spends one cycle in the settle state.
  assign settle_load_s = (SETTLE_TIME == CNT_ZERO) ? CNT_ONE : SETTLE_TIME;
  assign iter_inc_s    = iter_q + CNT_ONE;
  // cnt_q counts completed MEAS cycles, so the last allowed cycle is ADC_TIMEOUT-1.
  assign tmo_hit_s     = (ADC_TIMEOUT != CNT_ZERO) && (cnt_q >= (ADC_TIMEOUT - CNT_ONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    err_d   = err_q;
    if (!SYS_EN) begin
      state_d = S_IDLE;
      cnt_d   = CNT_ZERO;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CLEAR;
          err_d   = 1'b0;
        end
        S_CLEAR: begin
          iter_d  = CNT_ZERO;
          state_d = S_NEW_PERT;
        end
        S_NEW_PERT: state_d = S_SET_P;
        S_SET_P: begin
          cnt_d   = settle_load_s;
          state_d = S_SETTLE_P;
        end
        S_SETTLE_P, S_SETTLE_M: begin
          if (cnt_q <= CNT_ONE) begin
            cnt_d   = CNT_ZERO;
            state_d = (state_q == S_SETTLE_P) ? S_MEAS_P : S_MEAS_M;
          end else begin
            cnt_d   = cnt_q - CNT_ONE;
          end
        end
        S_MEAS_P, S_MEAS_M: begin
          if (ADC_DONE) begin
            cnt_d   = CNT_ZERO;
            state_d = (state_q == S_MEAS_P) ? S_LATCH_P : S_LATCH_M;
          end else if (tmo_hit_s) begin
            cnt_d   = CNT_ZERO;
            err_d   = 1'b1;
            state_d = S_FAULT;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        S_LATCH_P: state_d = S_SET_M;
        S_SET_M: begin
          cnt_d   = settle_load_s;
          state_d = S_SETTLE_M;
        end
        S_LATCH_M: state_d = S_UPDATE;
        S_UPDATE: begin
          iter_d = (iter_q == CNT_MAX) ? iter_q : iter_inc_s;
          if ((ITER_LIMIT != CNT_ZERO) && (iter_inc_s == ITER_LIMIT)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_NEW_PERT;
          end
        end
        S_DONE:  state_d = S_DONE;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ADC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      iter_q  <= CNT_ZERO;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ADC_EN      = 1'b0;
    REG_RST     = 1'b0;
    RNG_CLK     = 1'b0;
    DELTA_U_WRT = 1'b0;
    J_P_WRT     = 1'b0;
    J_M_WRT     = 1'b0;
    U_WRT       = 1'b0;
    DAC_SEL     = 2'd0;
    BUSY        = 1'b1;
    case (state_q)
      S_IDLE:     BUSY = 1'b0;
      S_CLEAR:    REG_RST = 1'b1;
      S_NEW_PERT: RNG_CLK = 1'b1;
      S_SET_P: begin
        DELTA_U_WRT = 1'b1;
        DAC_SEL     = 2'd1;
      end
      S_SETTLE_P: DAC_SEL = 2'd1;
      S_MEAS_P: begin
        ADC_EN  = 1'b1;
        DAC_SEL = 2'd1;
      end
      S_LATCH_P: begin
        J_P_WRT = 1'b1;
        DAC_SEL = 2'd1;
      end
      S_SET_M, S_SETTLE_M: DAC_SEL = 2'd2;
      S_MEAS_M: begin
        ADC_EN  = 1'b1;
        DAC_SEL = 2'd2;
      end
      S_LATCH_M: begin
        J_M_WRT = 1'b1;
        DAC_SEL = 2'd2;
      end
      S_UPDATE:   U_WRT = 1'b1;
      S_DONE:     BUSY = 1'b0;
      S_FAULT:    BUSY = 1'b0;
      default:    BUSY = 1'b0;
    endcase
  end

  assign FSM_STATE = state_q;
  assign ITER_CNT  = iter_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_spgd_seq_ctrl.sv
// Bench for spgd_seq_ctrl: a per-cycle vector table, a queue-based iteration model under
// randomized settle/latency/limit/timeout, and hand sequences for reset, fault and abort cases.
module tb_spgd_seq_ctrl;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n, sys_en, adc_done;
  logic [CW-1:0] settle_time, adc_timeout, iter_limit;
  logic          adc_en, reg_rst, rng_clk, delta_u_wrt, j_p_wrt, j_m_wrt, u_wrt;
  logic [1:0]    dac_sel;
  logic [3:0]    fsm_state;
  logic [CW-1:0] iter_cnt;
  logic          busy, err;

  logic adc_auto = 1'b0, adc_done_auto = 1'b0, adc_done_man = 1'b0;
  int   adc_lat = 1, adc_cnt = 0;
  int   errors = 0, checks = 0;

  assign adc_done = adc_auto ? adc_done_auto : adc_done_man;

  spgd_seq_ctrl #(.CNT_WIDTH(CW)) dut (
    .ADC_CLK(clk), .RST_N(rst_n), .SYS_EN(sys_en), .ADC_DONE(adc_done),
    .SETTLE_TIME(settle_time), .ADC_TIMEOUT(adc_timeout), .ITER_LIMIT(iter_limit),
    .ADC_EN(adc_en), .REG_RST(reg_rst), .RNG_CLK(rng_clk), .DELTA_U_WRT(delta_u_wrt),
    .J_P_WRT(j_p_wrt), .J_M_WRT(j_m_wrt), .U_WRT(u_wrt), .DAC_SEL(dac_sel),
    .FSM_STATE(fsm_state), .ITER_CNT(iter_cnt), .BUSY(busy), .ERR(err)
  );

  always #5 clk = ~clk;

  // ADC stand-in: answers adc_lat cycles after ADC_EN rises.
  always @(negedge clk) begin
    if (adc_auto && adc_en) begin
      adc_cnt++;
      adc_done_auto = (adc_cnt == adc_lat + 1);
    end else begin
      adc_cnt = 0;
      adc_done_auto = 1'b0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       en;
    logic       done;
    logic [3:0] st;
    logic [5:0] strb;   // {REG_RST, RNG_CLK, DELTA_U_WRT, J_P_WRT, J_M_WRT, U_WRT}
    logic [1:0] dac;
    logic       aen;
    logic       bsy;
    logic [31:0] it;
  } vec_t;

  typedef struct {
    int st;
    int it;   // -1: not checked
    bit er;
  } exp_t;

  task automatic wait_st_it(input int st, input int it, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (fsm_state == st && iter_cnt == it) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Expected per-cycle trace built from the iteration recipe, then compared cycle by cycle.
  task automatic run_model(input int s, input int lat, input int lim, input int tmo,
                           output int n_u, output int n_rng, output int len,
                           output bit ordered, output int last_st, output int last_it);
    exp_t q[$];
    int   it, se, exp_u;
    bit   flt;
    int   first[6];
    logic [5:0] sv;
    se    = (s == 0) ? 1 : s;
    flt   = (tmo != 0) && (lat + 1 > tmo);
    it    = 0;
    exp_u = 0;
    q.push_back('{1, -1, 1'b0});
    for (int k = 0; k < 64; k++) begin
      q.push_back('{2, it, 1'b0});
      q.push_back('{3, it, 1'b0});
      repeat (se) q.push_back('{4, it, 1'b0});
      if (flt) begin
        repeat (tmo) q.push_back('{5, it, 1'b0});
        repeat (3) q.push_back('{13, it, 1'b1});
        break;
      end
      repeat (lat + 1) q.push_back('{5, it, 1'b0});
      q.push_back('{6, it, 1'b0});
      q.push_back('{7, it, 1'b0});
      repeat (se) q.push_back('{8, it, 1'b0});
      repeat (lat + 1) q.push_back('{9, it, 1'b0});
      q.push_back('{10, it, 1'b0});
      q.push_back('{11, it, 1'b0});
      exp_u++;
      it++;
      if (lim != 0 && it == lim) begin
        repeat (3) q.push_back('{12, it, 1'b0});
        break;
      end
    end
    adc_auto = 1'b1; adc_lat = lat;
    settle_time = s; adc_timeout = tmo; iter_limit = lim;
    sys_en = 1'b1;
    n_u = 0; n_rng = 0;
    for (int k = 0; k < 6; k++) first[k] = -1;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      check("model_state", fsm_state, q[i].st);
      if (q[i].it >= 0) check("model_iter", iter_cnt, q[i].it);
      check("model_err", err, q[i].er);
      sv = {reg_rst, rng_clk, delta_u_wrt, j_p_wrt, j_m_wrt, u_wrt};
      for (int k = 0; k < 6; k++) if (sv[5-k] && first[k] < 0) first[k] = i;
      n_u   += int'(u_wrt);
      n_rng += int'(rng_clk);
    end
    last_st = fsm_state;
    last_it = iter_cnt;
    check("model_u_count", n_u, exp_u);
    ordered = (first[0] >= 0);
    for (int k = 1; k < 6; k++) if (first[k] <= first[k-1]) ordered = 1'b0;
    len = first[5] - first[1] + 1;
    sys_en = 1'b0;
    @(posedge clk); #1;
    check("model_idle_state", fsm_state, 0);
    check("model_idle_err", err, 0);
    adc_auto = 1'b0;
  endtask

  initial begin
    vec_t tbl[17];
    int   n_u, n_rng, len, last_st, last_it, n, cnt_bad;
    bit   ordered, ok;
    int   s, lat, lim, tmo;

    tbl[0]  = '{1'b1, 1'b0, 4'd1,  6'b100000, 2'd0, 1'b0, 1'b1, 32'd0};
    tbl[1]  = '{1'b1, 1'b0, 4'd2,  6'b010000, 2'd0, 1'b0, 1'b1, 32'd0};
    tbl[2]  = '{1'b1, 1'b0, 4'd3,  6'b001000, 2'd1, 1'b0, 1'b1, 32'd0};
    tbl[3]  = '{1'b1, 1'b0, 4'd4,  6'b000000, 2'd1, 1'b0, 1'b1, 32'd0};
    tbl[4]  = '{1'b1, 1'b1, 4'd4,  6'b000000, 2'd1, 1'b0, 1'b1, 32'd0};
    tbl[5]  = '{1'b1, 1'b0, 4'd5,  6'b000000, 2'd1, 1'b1, 1'b1, 32'd0};
    tbl[6]  = '{1'b1, 1'b0, 4'd5,  6'b000000, 2'd1, 1'b1, 1'b1, 32'd0};
    tbl[7]  = '{1'b1, 1'b1, 4'd6,  6'b000100, 2'd1, 1'b0, 1'b1, 32'd0};
    tbl[8]  = '{1'b1, 1'b0, 4'd7,  6'b000000, 2'd2, 1'b0, 1'b1, 32'd0};
    tbl[9]  = '{1'b1, 1'b0, 4'd8,  6'b000000, 2'd2, 1'b0, 1'b1, 32'd0};
    tbl[10] = '{1'b1, 1'b0, 4'd8,  6'b000000, 2'd2, 1'b0, 1'b1, 32'd0};
    tbl[11] = '{1'b1, 1'b0, 4'd9,  6'b000000, 2'd2, 1'b1, 1'b1, 32'd0};
    tbl[12] = '{1'b1, 1'b1, 4'd10, 6'b000010, 2'd2, 1'b0, 1'b1, 32'd0};
    tbl[13] = '{1'b1, 1'b0, 4'd11, 6'b000001, 2'd0, 1'b0, 1'b1, 32'd0};
    tbl[14] = '{1'b1, 1'b0, 4'd12, 6'b000000, 2'd0, 1'b0, 1'b0, 32'd1};
    tbl[15] = '{1'b1, 1'b0, 4'd12, 6'b000000, 2'd0, 1'b0, 1'b0, 32'd1};
    tbl[16] = '{1'b0, 1'b0, 4'd0,  6'b000000, 2'd0, 1'b0, 1'b0, 32'd1};

    rst_n = 1'b0; sys_en = 1'b0;
    settle_time = 2; adc_timeout = 0; iter_limit = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", fsm_state, 0);
    check("reset_iter", iter_cnt, 0);
    check("reset_strobes", {adc_en, reg_rst, rng_clk, delta_u_wrt, j_p_wrt, j_m_wrt, u_wrt, busy, err}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: one iteration with SETTLE_TIME=2, manual ADC_DONE, a stray pulse in SETTLE_P.
    for (int i = 0; i < 17; i++) begin
      sys_en = tbl[i].en; adc_done_man = tbl[i].done;
      @(posedge clk); #1;
      check("tbl_state", fsm_state, tbl[i].st);
      check("tbl_strobes", {reg_rst, rng_clk, delta_u_wrt, j_p_wrt, j_m_wrt, u_wrt}, tbl[i].strb);
      check("tbl_dac_sel", dac_sel, tbl[i].dac);
      check("tbl_adc_en", adc_en, tbl[i].aen);
      check("tbl_busy", busy, tbl[i].bsy);
      check("tbl_iter", iter_cnt, tbl[i].it);
    end
    adc_done_man = 1'b0;

    // Nominal: SETTLE_TIME=4, ADC answers 3 cycles after ADC_EN rises, one iteration.
    run_model(4, 3, 1, 0, n_u, n_rng, len, ordered, last_st, last_it);
    check("nominal_len", len, 22);
    check("nominal_order", ordered, 1);
    check("nominal_state", last_st, 12);
    check("nominal_iter", last_it, 1);

    // Three iterations with zero settle time.
    run_model(0, 2, 3, 0, n_u, n_rng, len, ordered, last_st, last_it);
    check("limit3_u_wrt", n_u, 3);
    check("limit3_rng_clk", n_rng, 3);
    check("limit3_state", last_st, 12);
    check("limit3_iter", last_it, 3);

    for (int t = 0; t < 10; t++) begin
      s   = $urandom_range(0, 5);
      lat = $urandom_range(0, 4);
      lim = $urandom_range(1, 3);
      tmo = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6);
      run_model(s, lat, lim, tmo, n_u, n_rng, len, ordered, last_st, last_it);
    end

    // Timeout: ADC never answers.
    adc_auto = 1'b0; adc_done_man = 1'b0;
    settle_time = 1; adc_timeout = 16; iter_limit = 0;
    sys_en = 1'b1;
    wait_st_it(5, 0, ok);
    check("fault_reach_meas", ok, 1);
    n = 0;
    while (fsm_state == 4'd5 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("fault_cycles", n, 16);
    check("fault_state", fsm_state, 13);
    check("fault_err", err, 1);
    check("fault_adc_en", adc_en, 0);
    check("fault_dac_sel", dac_sel, 0);
    sys_en = 1'b0;
    @(posedge clk); #1;
    check("fault_idle_state", fsm_state, 0);
    check("fault_idle_err", err, 0);

    // SYS_EN dropped during SETTLE_M of the second iteration.
    adc_auto = 1'b1; adc_lat = 1;
    settle_time = 3; adc_timeout = 0; iter_limit = 0;
    sys_en = 1'b1;
    wait_st_it(8, 1, ok);
    check("abort_reach_settle_m", ok, 1);
    sys_en = 1'b0;
    cnt_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) check("abort_state", fsm_state, 0);
      cnt_bad += int'(j_m_wrt) + int'(u_wrt) + int'(reg_rst);
    end
    check("abort_no_strobes", cnt_bad, 0);
    check("abort_iter", iter_cnt, 1);
    check("abort_dac_sel", dac_sel, 0);

    // ADC_DONE coincident with SYS_EN falling in MEAS_P.
    adc_auto = 1'b0; adc_done_man = 1'b0;
    settle_time = 2;
    sys_en = 1'b1;
    wait_st_it(5, 0, ok);
    check("coinc_reach_meas", ok, 1);
    adc_done_man = 1'b1; sys_en = 1'b0;
    @(posedge clk); #1;
    adc_done_man = 1'b0;
    check("coinc_state", fsm_state, 0);
    check("coinc_j_p_wrt", j_p_wrt, 0);
    @(posedge clk); #1;
    check("coinc_j_p_wrt_late", j_p_wrt, 0);
    check("coinc_state_hold", fsm_state, 0);

    // Asynchronous reset in SETTLE_P of the second iteration.
    adc_auto = 1'b1; adc_lat = 1;
    settle_time = 8;
    sys_en = 1'b1;
    wait_st_it(4, 1, ok);
    check("rst_reach_settle_p", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", fsm_state, 0);
    check("async_rst_iter", iter_cnt, 0);
    check("async_rst_dac_sel", dac_sel, 0);
    check("async_rst_outs", {adc_en, reg_rst, rng_clk, delta_u_wrt, j_p_wrt, j_m_wrt, u_wrt, busy, err}, 0);
    sys_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_state", fsm_state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
